// File: rtl/matinv_job_sequencer.sv
// -----------------------------------------------------------------------------
// matinv_job_sequencer
//
// Top-level controller for the 3x3 matrix-inversion output path. It accepts a
// job request, starts the inversion core, waits for it, latches the nine
// 16-bit inverse results into the holding register, then holds the serializer
// start until every byte has been shifted out. It reports success or error
// and counts successful jobs.
//
// Optional feature macro: MATINV_SEQ_WATCHDOG_EN
//   When defined, a per-wait-state watchdog bounds INV_WAIT and SER_WAIT to
//   TIMEOUT_CYCLES cycles and reports a timeout through err_code. When
//   undefined, there is no counter and the waits are unbounded.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   req          in   job request (level), sampled only in IDLE
//   ack          out  one-cycle pulse when req is accepted
//   busy         out  high in every state except IDLE
//   inv_start    out  one-cycle start pulse to the inversion core
//   inv_done     in   inversion complete (pulse or level)
//   inv_singular in   determinant zero, qualified by inv_done
//   latch_en     out  one-cycle capture enable for out_inv11..out_inv33
//   ser_start    out  serializer start, high for every SER_WAIT cycle
//   ser_done     in   serializer finished all 18 bytes
//   job_done     out  one-cycle pulse on successful completion
//   job_err      out  one-cycle pulse on error completion
//   err_code     out  00 none, 01 singular, 10 inv timeout, 11 ser timeout
//   job_count    out  successful jobs, wraps after all-ones
//   state_dbg    out  current FSM state, for observation only
//
// Handshakes: req/ack is a level request with a one-cycle acceptance pulse
// (ack is high in the same cycle that req is seen in IDLE); inv_start and
// inv_done/ser_start and ser_done are start/complete pairs where the done
// input is only looked at while the FSM is waiting for it.
// -----------------------------------------------------------------------------
module matinv_job_sequencer #(
    parameter int JOB_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    output logic                 ack,
    output logic                 busy,
    output logic                 inv_start,
    input  logic                 inv_done,
    input  logic                 inv_singular,
    output logic                 latch_en,
    output logic                 ser_start,
    input  logic                 ser_done,
    output logic                 job_done,
    output logic                 job_err,
    output logic [1:0]           err_code,
    output logic [JOB_CNT_W-1:0] job_count,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INV_GO   = 3'd1,
        S_INV_WAIT = 3'd2,
        S_LATCH    = 3'd3,
        S_SER_WAIT = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_SINGULAR = 2'b01;
    localparam logic [1:0] ERR_INV_TO   = 2'b10;
    localparam logic [1:0] ERR_SER_TO   = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] err_nxt;
    logic       to_hit;

`ifdef MATINV_SEQ_WATCHDOG_EN
    logic [TO_CNT_W-1:0] to_cnt;

    // Counter sits at zero outside the wait states, so the first cycle of
    // either wait state always sees 0 and the counter restarts per state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == S_INV_WAIT || state == S_SER_WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign to_hit = (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            err_code  <= ERR_NONE;
            job_count <= '0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
            if (state == S_DONE) begin
                job_count <= job_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        ack       = 1'b0;
        inv_start = 1'b0;
        latch_en  = 1'b0;
        ser_start = 1'b0;
        job_done  = 1'b0;
        job_err   = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_INV_GO;
                    // ack is combinational from req; gating with rst keeps it
                    // low while reset is held even if req is already high.
                    ack       = rst;
                    err_nxt   = ERR_NONE;
                end
            end
            S_INV_GO: begin
                inv_start = 1'b1;
                state_nxt = S_INV_WAIT;
            end
            S_INV_WAIT: begin
                // A done arriving on the terminal-count cycle takes priority.
                if (inv_done) begin
                    if (inv_singular) begin
                        state_nxt = S_ERR;
                        err_nxt   = ERR_SINGULAR;
                    end else begin
                        state_nxt = S_LATCH;
                    end
                end else if (to_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_INV_TO;
                end
            end
            S_LATCH: begin
                latch_en  = 1'b1;
                state_nxt = S_SER_WAIT;
            end
            S_SER_WAIT: begin
                ser_start = 1'b1;
                if (ser_done) begin
                    state_nxt = S_DONE;
                end else if (to_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_SER_TO;
                end
            end
            S_DONE: begin
                job_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                job_err   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

endmodule
